// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Central sequencer for the five-stage core. It decides, combinationally from
// the EX-stage requests and the data-memory busy flag, whether the PC and the
// four stage registers are written, and which stage registers load a bubble.
// A small FSM tracks the post-redirect IF/ID flush window and memory freezes.
//
// Optional feature macro: PIPELINE_CTRL_PERF_EN
//   defined     -> perf_cycles / perf_stalls / perf_flushes are live counters
//   not defined -> counter registers are absent and the outputs read 0
//
// Parameters
//   FLUSH_CYCLES  cycles IF_ID_flush stays high after a redirect (>= 1)
//   CNT_W         performance counter width
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   EX_stall                   load-use hazard: hold IF/ID/EX, bubble EX/MEM
//   EX_branch, EX_zero         conditional branch and its taken condition
//   EX_unconditional_jmp       jump in EX
//   EX_target[31:0]            redirect address for the EX instruction
//   mem_busy                   data memory not ready: freeze everything
//   pc_we, pc_sel, pc_target   PC write enable, target select, target value
//   *_we                       stage register write enables
//   *_flush                    load a bubble into the stage register
//   perf_*[CNT_W-1:0]          performance counters
//   dbg_state[1:0]             registered FSM state (RUN/STALL/FLUSH/FREEZE)
//
// Handshake note: there is no valid/ready pair here; every control output is
// a pure function of this cycle's inputs plus registered state, so a decision
// takes effect on the rising edge that ends the cycle in which it is made.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              EX_stall,
   input  logic              EX_branch,
   input  logic              EX_zero,
   input  logic              EX_unconditional_jmp,
   input  logic [31:0]       EX_target,
   input  logic              mem_busy,
   output logic              pc_we,
   output logic              pc_sel,
   output logic [31:0]       pc_target,
   output logic              IF_ID_we,
   output logic              ID_EX_we,
   output logic              EX_MEM_we,
   output logic              MEM_WB_we,
   output logic              IF_ID_flush,
   output logic              ID_EX_flush,
   output logic              EX_MEM_flush,
   output logic [CNT_W-1:0]  perf_cycles,
   output logic [CNT_W-1:0]  perf_stalls,
   output logic [CNT_W-1:0]  perf_flushes,
   output logic [1:0]        dbg_state
);

   // Window counter only needs to hold FLUSH_CYCLES-1.
   localparam int WIN_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_STALL  = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_FREEZE = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [WIN_W-1:0]  win_q, win_d;
   logic              started_q, started_d;
   logic              taken;

   assign taken = EX_unconditional_jmp | (EX_branch & EX_zero);

   // ---------------------------------------------------------------------------
   // Next state and control outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = ST_RUN;
      win_d        = win_q;
      started_d    = 1'b1;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      IF_ID_we     = 1'b0;
      ID_EX_we     = 1'b0;
      EX_MEM_we    = 1'b0;
      MEM_WB_we    = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_MEM_flush = 1'b0;

      if (!started_q) begin
         // First cycle out of reset: nothing is written, nothing flushed.
         state_d = ST_RUN;
      end else if (mem_busy) begin
         // Freeze: every enable low, window counter holds.
         state_d = ST_FREEZE;
      end else if (EX_stall) begin
         // Branch operands are not valid yet, so taken is ignored; the
         // window counter holds because IF/ID is not being written.
         state_d      = ST_STALL;
         EX_MEM_we    = 1'b1;
         MEM_WB_we    = 1'b1;
         EX_MEM_flush = 1'b1;
      end else begin
         pc_we     = 1'b1;
         IF_ID_we  = 1'b1;
         ID_EX_we  = 1'b1;
         EX_MEM_we = 1'b1;
         MEM_WB_we = 1'b1;
         if (taken) begin
            pc_sel      = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            win_d       = WIN_LOAD;
         end else if (win_q != '0) begin
            IF_ID_flush = 1'b1;
            win_d       = win_q - WIN_W'(1);
         end
         state_d = (win_d != '0) ? ST_FLUSH : ST_RUN;
      end
   end

   assign pc_target = pc_sel ? EX_target : 32'd0;
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         win_q     <= '0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         started_q <= started_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Performance counters (wrap modulo 2^CNT_W)
   // ---------------------------------------------------------------------------
`ifdef PIPELINE_CTRL_PERF_EN
   logic [CNT_W-1:0] perf_cycles_q,  perf_cycles_d;
   logic [CNT_W-1:0] perf_stalls_q,  perf_stalls_d;
   logic [CNT_W-1:0] perf_flushes_q, perf_flushes_d;
   logic             stall_cyc;
   logic             flush_acc;

   always_comb begin
      stall_cyc      = started_q & ((state_d == ST_STALL) | (state_d == ST_FREEZE));
      flush_acc      = started_q & taken & ~mem_busy & ~EX_stall;
      perf_cycles_d  = perf_cycles_q;
      perf_stalls_d  = perf_stalls_q;
      perf_flushes_d = perf_flushes_q;
      if (started_q) perf_cycles_d  = perf_cycles_q + CNT_W'(1);
      if (stall_cyc) perf_stalls_d  = perf_stalls_q + CNT_W'(1);
      if (flush_acc) perf_flushes_d = perf_flushes_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles_q  <= '0;
         perf_stalls_q  <= '0;
         perf_flushes_q <= '0;
      end else begin
         perf_cycles_q  <= perf_cycles_d;
         perf_stalls_q  <= perf_stalls_d;
         perf_flushes_q <= perf_flushes_d;
      end
   end

   assign perf_cycles  = perf_cycles_q;
   assign perf_stalls  = perf_stalls_q;
   assign perf_flushes = perf_flushes_q;
`else
   assign perf_cycles  = '0;
   assign perf_stalls  = '0;
   assign perf_flushes = '0;
`endif

endmodule
